// File: rtl/esfa_cell_sequencer.sv
// Command front-end for the MemoryCell array: issues one host command on the shared
// cell broadcast bus and reduces the cells' registered replies into one response.
module esfa_cell_sequencer #(
  parameter int N_CELLS = 8,
  parameter int W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [W-1:0]         cmd_key,
  input  logic [W-1:0]         cmd_index,
  input  logic [W-1:0]         cmd_value,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [W-1:0]         rsp_data,
  output logic [W-1:0]         rsp_aux,
  output logic [7:0]           bus_selector,
  output logic [W-1:0]         bus_metadata,
  output logic                 bus_is_meta,
  output logic [W-1:0]         bus_index,
  output logic [W-1:0]         bus_value,
  input  logic [N_CELLS-1:0]   cell_bool,
  input  logic [N_CELLS*W-1:0] cell_result,
  input  logic [N_CELLS*W-1:0] cell_context
);

  localparam int IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_ALLOC  = 2'd1;
  localparam logic [1:0] OP_ENCODE = 2'd2;

  localparam logic [7:0] SEL_WRITE  = 8'd0;
  localparam logic [7:0] SEL_LOOKUP = 8'd1;
  localparam logic [7:0] SEL_ENCODE = 8'd2;
  localparam logic [7:0] SEL_PARK   = 8'd5;
  localparam logic [7:0] SEL_ENRANK = 8'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ISSUE_W, S_WAIT_W, S_RESP
  } state_t;

  // Lowest-index set bit wins; result is 0 when nothing is set (callers gate with |v).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CELLS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  state_t           r_state,     w_state_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic             r_rsp_hit,   w_rsp_hit_nxt;
  logic [W-1:0]     r_rsp_data,  w_rsp_data_nxt;
  logic [W-1:0]     r_rsp_aux,   w_rsp_aux_nxt;
  logic [7:0]       r_sel,       w_sel_nxt;
  logic [W-1:0]     r_meta,      w_meta_nxt;
  logic             r_is_meta,   w_is_meta_nxt;
  logic [W-1:0]     r_bidx,      w_bidx_nxt;
  logic [W-1:0]     r_bval,      w_bval_nxt;
  logic [1:0]       r_op,        w_op_nxt;
  logic [W-1:0]     r_idx,       w_idx_nxt;
  logic [W-1:0]     r_val,       w_val_nxt;
  logic [IDX_W-1:0] r_h,         w_h_nxt;

  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic [W-1:0]     w_win_result;
  logic [W-1:0]     w_win_context;
  logic             w_h_bool;
  logic [W-1:0]     w_h_context;

  assign w_win         = lowest_set(cell_bool);
  assign w_any         = |cell_bool;
  assign w_win_result  = cell_result[int'(w_win) * W +: W];
  assign w_win_context = cell_context[int'(w_win) * W +: W];
  assign w_h_bool      = cell_bool[r_h];
  assign w_h_context   = cell_context[int'(r_h) * W +: W];

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_hit_nxt   = r_rsp_hit;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_aux_nxt   = r_rsp_aux;
    // Bus parks unless a state below explicitly loads it for the next cycle.
    w_sel_nxt       = SEL_PARK;
    w_meta_nxt      = '0;
    w_is_meta_nxt   = 1'b0;
    w_bidx_nxt      = '0;
    w_bval_nxt      = '0;
    w_op_nxt        = r_op;
    w_idx_nxt       = r_idx;
    w_val_nxt       = r_val;
    w_h_nxt         = r_h;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_op_nxt    = cmd_op;
          w_idx_nxt   = cmd_index;
          w_val_nxt   = cmd_value;
          w_state_nxt = S_ISSUE;
          case (cmd_op)
            OP_LOOKUP: begin
              w_sel_nxt     = SEL_LOOKUP;
              w_meta_nxt    = cmd_key;
              w_is_meta_nxt = 1'b1;
              w_bidx_nxt    = cmd_index;
            end
            OP_ALLOC: w_sel_nxt = SEL_PARK;
            OP_ENCODE: begin
              w_sel_nxt     = SEL_ENCODE;
              w_meta_nxt    = cmd_key;
              w_is_meta_nxt = 1'b1;
            end
            default: begin
              w_sel_nxt     = SEL_ENRANK;
              w_meta_nxt    = cmd_key;
              w_is_meta_nxt = 1'b1;
            end
          endcase
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_op == OP_ALLOC && w_any) begin
          // Free cell found: the write goes to the lowest free handle.
          w_h_nxt       = w_win;
          w_sel_nxt     = SEL_WRITE;
          w_meta_nxt    = W'(w_win);
          w_is_meta_nxt = 1'b1;
          w_bidx_nxt    = r_idx;
          w_bval_nxt    = r_val;
          w_state_nxt   = S_ISSUE_W;
        end else begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_hit_nxt   = w_any;
          w_rsp_data_nxt  = w_any ? w_win_result  : '0;
          w_rsp_aux_nxt   = w_any ? w_win_context : '0;
          w_state_nxt     = S_RESP;
        end
      end
      S_ISSUE_W: w_state_nxt = S_WAIT_W;
      S_WAIT_W: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_hit_nxt   = w_h_bool;
        w_rsp_data_nxt  = W'(r_h);
        w_rsp_aux_nxt   = w_h_context;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_aux   <= '0;
      r_sel       <= SEL_PARK;
      r_meta      <= '0;
      r_is_meta   <= 1'b0;
      r_bidx      <= '0;
      r_bval      <= '0;
      r_op        <= OP_LOOKUP;
      r_idx       <= '0;
      r_val       <= '0;
      r_h         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_hit   <= w_rsp_hit_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_aux   <= w_rsp_aux_nxt;
      r_sel       <= w_sel_nxt;
      r_meta      <= w_meta_nxt;
      r_is_meta   <= w_is_meta_nxt;
      r_bidx      <= w_bidx_nxt;
      r_bval      <= w_bval_nxt;
      r_op        <= w_op_nxt;
      r_idx       <= w_idx_nxt;
      r_val       <= w_val_nxt;
      r_h         <= w_h_nxt;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_hit      = r_rsp_hit;
  assign rsp_data     = r_rsp_data;
  assign rsp_aux      = r_rsp_aux;
  assign bus_selector = r_sel;
  assign bus_metadata = r_meta;
  assign bus_is_meta  = r_is_meta;
  assign bus_index    = r_bidx;
  assign bus_value    = r_bval;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Randomized bench for esfa_cell_sequencer; the cell array is emulated as stimulus arrays.
module tb_esfa_cell_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_key, cmd_index, cmd_value;
  logic        rsp_valid, rsp_ready, rsp_hit;
  logic [7:0]  rsp_data, rsp_aux;
  logic [7:0]  bus_selector, bus_metadata, bus_index, bus_value;
  logic        bus_is_meta;
  logic [7:0]  cell_bool;
  logic [63:0] cell_result, cell_context;

  // Emulated cell replies: phase 1 is seen by the first capture, phase 2 after a write.
  logic       cb [8];
  logic [7:0] cr [8];
  logic [7:0] cc [8];
  logic       cb2[8];
  logic [7:0] cc2[8];

  int n_checks = 0;
  int n_pass   = 0;
  int sel0_run = 0;
  int sel0_max = 0;
  int sel0_total = 0;

  logic [7:0] sel_tab[4] = '{8'd1, 8'd5, 8'd2, 8'd6};

  typedef struct {
    int         lat;
    logic [7:0] isel, imeta, iidx, ival;
    logic       iism;
    int         nsel0;
    logic [7:0] wmeta, widx, wval;
    logic       wism;
    int         nbad;
  } obs_t;

  typedef struct {
    int         lat;
    logic       hit;
    logic [7:0] data, aux;
    int         nsel0;
  } exp_t;

  esfa_cell_sequencer #(.N_CELLS(8), .W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_index(cmd_index), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .rsp_aux(rsp_aux),
    .bus_selector(bus_selector), .bus_metadata(bus_metadata), .bus_is_meta(bus_is_meta),
    .bus_index(bus_index), .bus_value(bus_value),
    .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context)
  );

  always #5 clk = ~clk;

  always_comb begin
    cell_bool    = '0;
    cell_result  = '0;
    cell_context = '0;
    for (int i = 0; i < 8; i++) begin
      cell_bool[i]          = cb[i];
      cell_result[i*8 +: 8] = cr[i];
      cell_context[i*8 +: 8] = cc[i];
    end
  end

  always @(negedge clk) begin
    if (bus_selector == 8'd0) begin
      sel0_run++;
      sel0_total++;
      if (sel0_run > sel0_max) sel0_max = sel0_run;
    end else begin
      sel0_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cells(input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 8; i++) begin
      cb[i]  = b1[i];
      cb2[i] = b2[i];
      cr[i]  = 8'($urandom);
      cc[i]  = 8'($urandom);
      cc2[i] = 8'($urandom);
    end
  endtask

  // Reference: first responding cell wins; an allocation with a free cell writes it
  // and reports the post-write reply of that handle two cycles later.
  function automatic exp_t model(input logic [1:0] op);
    exp_t e;
    int   win;
    win = -1;
    for (int i = 0; i < 8; i++) if (cb[i] && win < 0) win = i;
    if (op == 2'd1 && win >= 0) begin
      e.lat = 4; e.hit = cb2[win]; e.data = 8'(win); e.aux = cc2[win]; e.nsel0 = 1;
    end else begin
      e.lat = 2; e.hit = (win >= 0); e.nsel0 = 0;
      e.data = (win >= 0) ? cr[win] : 8'h00;
      e.aux  = (win >= 0) ? cc[win] : 8'h00;
    end
    return e;
  endfunction

  task automatic drive_cmd(input logic [1:0] op, input logic [7:0] key, idx, val,
                           output obs_t o);
    o = '{default: 0};
    o.lat = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_index = idx; cmd_value = val;
    tick();
    cmd_valid = 1'b0;
    o.isel = bus_selector; o.imeta = bus_metadata; o.iism = bus_is_meta;
    o.iidx = bus_index; o.ival = bus_value;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus_selector == 8'd0) begin
        o.nsel0++;
        o.wmeta = bus_metadata; o.widx = bus_index; o.wval = bus_value; o.wism = bus_is_meta;
        for (int i = 0; i < 8; i++) begin
          cb[i] = cb2[i];
          cc[i] = cc2[i];
        end
      end else if (bus_selector != 8'd5 || bus_metadata != 0 || bus_is_meta ||
                   bus_index != 0 || bus_value != 0) begin
        o.nbad++;
      end
      if (rsp_valid) begin
        o.lat = c;
        break;
      end
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_key = 0; cmd_index = 0; cmd_value = 0;
    set_cells(8'h00, 8'h00);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    else n_pass++;
    n_checks++;
    if (bus_selector !== 8'd5 || bus_is_meta !== 1'b0 || bus_metadata !== 0)
      $display("FAIL reset_bus: got sel=%0d meta=%h ism=%b want sel=5 meta=00 ism=0",
               bus_selector, bus_metadata, bus_is_meta);
    else n_pass++;
    n_checks++;
    if (rsp_hit !== 1'b0 || rsp_data !== 0 || rsp_aux !== 0)
      $display("FAIL reset_rsp_fields: got hit=%b data=%h aux=%h want 0/00/00",
               rsp_hit, rsp_data, rsp_aux);
    else n_pass++;
  endtask

  task automatic test_alloc_empty();
    obs_t o;
    set_cells(8'hFF, 8'hFF);
    drive_cmd(2'd1, 8'h00, 8'd3, 8'h2A, o);
    n_checks++;
    if (o.lat !== 4 || rsp_hit !== 1'b1 || rsp_data !== 8'h00 || rsp_aux !== cc2[0])
      $display("FAIL alloc_empty_rsp: got lat=%0d hit=%b data=%h aux=%h want 4/1/00/%h",
               o.lat, rsp_hit, rsp_data, rsp_aux, cc2[0]);
    else n_pass++;
    n_checks++;
    if (o.nsel0 !== 1 || o.wmeta !== 8'h00 || o.widx !== 8'd3 || o.wval !== 8'h2A || o.wism !== 1'b1)
      $display("FAIL alloc_empty_write: got n=%0d meta=%h idx=%h val=%h ism=%b want 1/00/03/2a/1",
               o.nsel0, o.wmeta, o.widx, o.wval, o.wism);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_lookup_after_alloc();
    obs_t o;
    set_cells(8'h01, 8'h00);
    cr[0] = 8'h2A; cc[0] = 8'h01;
    drive_cmd(2'd0, 8'h00, 8'd3, 8'h00, o);
    n_checks++;
    if (o.lat !== 2 || rsp_hit !== 1'b1 || rsp_data !== 8'h2A || rsp_aux !== 8'h01)
      $display("FAIL lookup_rsp: got lat=%0d hit=%b data=%h aux=%h want 2/1/2a/01",
               o.lat, rsp_hit, rsp_data, rsp_aux);
    else n_pass++;
    n_checks++;
    if (o.isel !== 8'd1 || o.imeta !== 8'h00 || o.iism !== 1'b1 || o.iidx !== 8'd3)
      $display("FAIL lookup_bus: got sel=%0d meta=%h ism=%b idx=%h want 1/00/1/03",
               o.isel, o.imeta, o.iism, o.iidx);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_alloc_full();
    obs_t o;
    set_cells(8'h00, 8'hFF);
    drive_cmd(2'd1, 8'h00, 8'd7, 8'h55, o);
    n_checks++;
    if (o.lat !== 2 || rsp_hit !== 1'b0 || rsp_data !== 0 || rsp_aux !== 0 || o.nsel0 !== 0)
      $display("FAIL alloc_full: got lat=%0d hit=%b data=%h aux=%h sel0=%0d want 2/0/00/00/0",
               o.lat, rsp_hit, rsp_data, rsp_aux, o.nsel0);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_priority();
    obs_t o;
    set_cells(8'b0010_0100, 8'h00);
    cr[2] = 8'h11; cc[2] = 8'h22; cr[5] = 8'h55; cc[5] = 8'h66;
    drive_cmd(2'd0, 8'h04, 8'd1, 8'h00, o);
    n_checks++;
    if (rsp_hit !== 1'b1 || rsp_data !== 8'h11 || rsp_aux !== 8'h22)
      $display("FAIL priority_two_hits: got hit=%b data=%h aux=%h want 1/11/22",
               rsp_hit, rsp_data, rsp_aux);
    else n_pass++;
    release_rsp();
    set_cells(8'h00, 8'h00);
    drive_cmd(2'd3, 8'd9, 8'd0, 8'h00, o);
    n_checks++;
    if (o.lat !== 2 || rsp_hit !== 1'b0 || rsp_data !== 0 || o.isel !== 8'd6 || o.imeta !== 8'd9)
      $display("FAIL enrank_miss: got lat=%0d hit=%b data=%h sel=%0d meta=%h want 2/0/00/6/09",
               o.lat, rsp_hit, rsp_data, o.isel, o.imeta);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_hold();
    obs_t o;
    logic ok;
    set_cells(8'b1000_0000, 8'h00);
    cr[7] = 8'hC3; cc[7] = 8'h3C;
    drive_cmd(2'd2, 8'd7, 8'd0, 8'h00, o);
    for (int c = 0; c < 5; c++) begin
      tick();
      ok = rsp_valid === 1'b1 && rsp_hit === 1'b1 && rsp_data === 8'hC3 &&
           rsp_aux === 8'h3C && cmd_ready === 1'b0;
      n_checks++;
      if (!ok)
        $display("FAIL hold_stable: got v=%b hit=%b data=%h aux=%h rdy=%b want 1/1/c3/3c/0",
                 rsp_valid, rsp_hit, rsp_data, rsp_aux, cmd_ready);
      else n_pass++;
    end
    release_rsp();
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL hold_release: got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t       o;
    exp_t       e;
    logic [1:0] op;
    logic [7:0] key, idx, val, b1;
    int         hold;
    logic       ok;
    for (int t = 0; t < 60; t++) begin
      op  = 2'($urandom);
      key = 8'($urandom); idx = 8'($urandom); val = 8'($urandom);
      b1  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      set_cells(b1, 8'($urandom));
      e = model(op);
      drive_cmd(op, key, idx, val, o);
      n_checks++;
      if (o.lat !== e.lat || rsp_hit !== e.hit || rsp_data !== e.data || rsp_aux !== e.aux)
        $display("FAIL rand_rsp[%0d]: got lat=%0d hit=%b data=%h aux=%h want %0d/%b/%h/%h",
                 t, o.lat, rsp_hit, rsp_data, rsp_aux, e.lat, e.hit, e.data, e.aux);
      else n_pass++;
      ok = o.isel === sel_tab[op] && o.iism === (op != 2'd1) &&
           o.imeta === ((op == 2'd1) ? 8'h00 : key) &&
           o.iidx === ((op == 2'd0) ? idx : 8'h00) && o.ival === 8'h00;
      n_checks++;
      if (!ok)
        $display("FAIL rand_issue_bus[%0d]: got sel=%0d meta=%h ism=%b idx=%h val=%h op=%0d",
                 t, o.isel, o.imeta, o.iism, o.iidx, o.ival, op);
      else n_pass++;
      ok = o.nsel0 === e.nsel0 && o.nbad === 0 &&
           (e.nsel0 == 0 || (o.wmeta === e.data && o.widx === idx && o.wval === val && o.wism));
      n_checks++;
      if (!ok)
        $display("FAIL rand_write_bus[%0d]: got n=%0d bad=%0d meta=%h idx=%h val=%h want n=%0d meta=%h idx=%h val=%h",
                 t, o.nsel0, o.nbad, o.wmeta, o.widx, o.wval, e.nsel0, e.data, idx, val);
      else n_pass++;
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== e.hit || rsp_data !== e.data || rsp_aux !== e.aux)
          $display("FAIL rand_hold[%0d]: got v=%b hit=%b data=%h aux=%h want 1/%b/%h/%h",
                   t, rsp_valid, rsp_hit, rsp_data, rsp_aux, e.hit, e.data, e.aux);
        else n_pass++;
      end
      release_rsp();
    end
  endtask

  task automatic test_reset_mid_write();
    int   seen;
    int   snap;
    logic ok;
    set_cells(8'hF0, 8'hF0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_key = 0; cmd_index = 8'd1; cmd_value = 8'h77;
    tick();
    cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      tick();
      if (bus_selector == 8'd0) seen = 1;
    end
    n_checks++;
    if (seen != 1) $display("FAIL midreset_reach_write: got sel=%0d want 0 within 6 cycles", bus_selector);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus_selector !== 8'd5 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus_is_meta !== 1'b0)
      $display("FAIL midreset_state: got sel=%0d v=%b rdy=%b ism=%b want 5/0/1/0",
               bus_selector, rsp_valid, cmd_ready, bus_is_meta);
    else n_pass++;
    snap = sel0_total;
    reset = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    end
    n_checks++;
    if (!ok || sel0_total != snap)
      $display("FAIL midreset_after: got stable=%b sel0_cycles=%0d want 1/%0d", ok, sel0_total, snap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alloc_empty();
    test_lookup_after_alloc();
    test_alloc_full();
    test_priority();
    test_hold();
    test_random();
    test_reset_mid_write();
    n_checks++;
    if (sel0_max > 1) $display("FAIL sel0_max_run: got %0d want <=1", sel0_max);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
